// File: rtl/cla_pipe_adder16.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder16
// Purpose  : Two-stage pipelined 16-bit carry look-ahead adder/subtractor with
//            valid/ready handshakes. Stage 1 registers bit propagate/generate
//            and 4-bit group propagate/generate. Stage 2 performs the
//            second-level look-ahead across the four groups, expands the group
//            carries into bit carries, and registers sum and flags.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            in_valid / in_ready  - input handshake
//            a, b, cin, op_sub    - operands, carry-in, subtract select
//            out_valid/out_ready  - output handshake
//            sum, cout, ovf       - result, carry out of bit 15, signed overflow
//            grp_p, grp_g         - block propagate / generate of all 16 bits
// Revision : 1.0  initial release
// ============================================================================
module cla_pipe_adder16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   input  logic        op_sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] sum,
   output logic        cout,
   output logic        ovf,
   output logic        grp_p,
   output logic        grp_g
);

   localparam int GROUPS    = 4;
   localparam int GRP_BITS  = 4;

   // ------------------------------------------------------------------
   // Handshake / stall control
   // ------------------------------------------------------------------
   logic s1_valid;
   logic s2_free;
   logic s1_adv;
   logic in_fire;

   assign s2_free  = !out_valid | out_ready;
   assign s1_adv   = s1_valid & s2_free;
   // S1 can be refilled in the same cycle it drains, hence the s2_free term.
   assign in_ready = !rst & (!s1_valid | s2_free);
   assign in_fire  = in_valid & in_ready;

   // ------------------------------------------------------------------
   // Stage 1 combinational: operand conditioning and group P/G
   // ------------------------------------------------------------------
   logic [15:0] b_eff;
   logic        c0_in;
   logic [15:0] p_in;
   logic [15:0] g_in;
   logic [3:0]  bp_in;
   logic [3:0]  bg_in;

   // Subtract is A + ~B + 1; cin is deliberately ignored in that mode.
   assign b_eff = op_sub ? ~b : b;
   assign c0_in = op_sub ? 1'b1 : cin;
   assign p_in  = a ^ b_eff;
   assign g_in  = a & b_eff;

   for (genvar k = 0; k < GROUPS; k++) begin : g_grp_pg
      localparam int B0 = k * GRP_BITS;
      assign bp_in[k] = &p_in[B0 +: GRP_BITS];
      assign bg_in[k] = g_in[B0+3]
                      | (p_in[B0+3] & g_in[B0+2])
                      | (p_in[B0+3] & p_in[B0+2] & g_in[B0+1])
                      | (p_in[B0+3] & p_in[B0+2] & p_in[B0+1] & g_in[B0]);
   end

   // ------------------------------------------------------------------
   // Stage 1 register
   // ------------------------------------------------------------------
   logic [15:0] s1_p;
   logic [15:0] s1_g;
   logic [3:0]  s1_bp;
   logic [3:0]  s1_bg;
   logic        s1_c0;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_p     <= '0;
         s1_g     <= '0;
         s1_bp    <= '0;
         s1_bg    <= '0;
         s1_c0    <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_p     <= p_in;
         s1_g     <= g_in;
         s1_bp    <= bp_in;
         s1_bg    <= bg_in;
         s1_c0    <= c0_in;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2 combinational: second-level look-ahead
   // ------------------------------------------------------------------
   // gc[k] is the carry into group k; gc[4] is the carry out of bit 15.
   // Each is a flat sum-of-products of group P/G and c0, not a ripple.
   logic [4:0]  gc;
   logic [15:0] carry;
   logic [15:0] sum_nxt;
   logic        ovf_nxt;
   logic        grp_p_nxt;
   logic        grp_g_nxt;

   assign gc[0] = s1_c0;
   assign gc[1] = s1_bg[0]
                | (s1_bp[0] & s1_c0);
   assign gc[2] = s1_bg[1]
                | (s1_bp[1] & s1_bg[0])
                | (s1_bp[1] & s1_bp[0] & s1_c0);
   assign gc[3] = s1_bg[2]
                | (s1_bp[2] & s1_bg[1])
                | (s1_bp[2] & s1_bp[1] & s1_bg[0])
                | (s1_bp[2] & s1_bp[1] & s1_bp[0] & s1_c0);
   assign gc[4] = s1_bg[3]
                | (s1_bp[3] & s1_bg[2])
                | (s1_bp[3] & s1_bp[2] & s1_bg[1])
                | (s1_bp[3] & s1_bp[2] & s1_bp[1] & s1_bg[0])
                | (s1_bp[3] & s1_bp[2] & s1_bp[1] & s1_bp[0] & s1_c0);

   // Bit carries inside each group, expanded from that group's carry-in.
   for (genvar k = 0; k < GROUPS; k++) begin : g_grp_carry
      localparam int B0 = k * GRP_BITS;
      assign carry[B0]   = gc[k];
      assign carry[B0+1] = s1_g[B0]
                         | (s1_p[B0] & gc[k]);
      assign carry[B0+2] = s1_g[B0+1]
                         | (s1_p[B0+1] & s1_g[B0])
                         | (s1_p[B0+1] & s1_p[B0] & gc[k]);
      assign carry[B0+3] = s1_g[B0+2]
                         | (s1_p[B0+2] & s1_g[B0+1])
                         | (s1_p[B0+2] & s1_p[B0+1] & s1_g[B0])
                         | (s1_p[B0+2] & s1_p[B0+1] & s1_p[B0] & gc[k]);
   end

   assign sum_nxt   = s1_p ^ carry;
   assign ovf_nxt   = gc[4] ^ carry[15];
   assign grp_p_nxt = &s1_bp;
   // Block generate is independent of c0.
   assign grp_g_nxt = s1_bg[3]
                    | (s1_bp[3] & s1_bg[2])
                    | (s1_bp[3] & s1_bp[2] & s1_bg[1])
                    | (s1_bp[3] & s1_bp[2] & s1_bp[1] & s1_bg[0]);

   // ------------------------------------------------------------------
   // Output register: payload only changes when a new result is loaded,
   // so it stays stable across a stall.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         grp_p     <= 1'b0;
         grp_g     <= 1'b0;
      end else if (s1_adv) begin
         out_valid <= 1'b1;
         sum       <= sum_nxt;
         cout      <= gc[4];
         ovf       <= ovf_nxt;
         grp_p     <= grp_p_nxt;
         grp_g     <= grp_g_nxt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder16.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_pipe_adder16
// Purpose  : Self-checking bench for cla_pipe_adder16 using a table of
//            directed vectors with hand-computed results, plus sequences for
//            streaming, backpressure and reset mid-flight.
// Revision : 1.0  initial release
// ============================================================================
module tb_cla_pipe_adder16;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        op_sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        grp_p;
   logic        grp_g;

   cla_pipe_adder16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .grp_p     (grp_p),
      .grp_g     (grp_g)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        op_sub;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        gp;
      logic        gg;
   } vec_t;

   localparam int NVEC = 14;
   vec_t tbl [NVEC];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int cur_idx  = 0;
   int mon_idx  = 0;
   int nin      = 0;
   int nout     = 0;
   int in_cycle  [64];
   int out_cycle [64];
   int exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input int i);
      cur_idx  = i;
      a        = tbl[i].a;
      b        = tbl[i].b;
      cin      = tbl[i].cin;
      op_sub   = tbl[i].op_sub;
      in_valid = 1'b1;
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: on every output transfer compare against the oldest
   // accepted beat's table entry.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out actual_sum=0x%0h required=no result", sum);
            end else begin
               mon_idx = exp_q.pop_front();
               chk($sformatf("sum[v%0d]",  mon_idx), sum,   tbl[mon_idx].sum);
               chk($sformatf("cout[v%0d]", mon_idx), cout,  tbl[mon_idx].cout);
               chk($sformatf("ovf[v%0d]",  mon_idx), ovf,   tbl[mon_idx].ovf);
               chk($sformatf("gp[v%0d]",   mon_idx), grp_p, tbl[mon_idx].gp);
               chk($sformatf("gg[v%0d]",   mon_idx), grp_g, tbl[mon_idx].gg);
               if (nout < 64) out_cycle[nout] = cyc;
               nout++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(cur_idx);
            if (nin < 64) in_cycle[nin] = cyc;
            nin++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int i0;
      int acc;
      //          a         b         cin   sub   sum       cout  ovf   gp    gg
      tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum",       sum,       0);
      chk("rst_flags",     {cout, ovf, grp_p, grp_g}, 0);
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Directed vectors, one at a time, with latency check
      for (int i = 0; i < NVEC; i++) begin
         drive(i);
         @(negedge clk);
         chk($sformatf("idle_ready[v%0d]", i), in_ready, 1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("lat_n1_valid[v%0d]", i), out_valid, 0);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("lat_n2_valid[v%0d]", i), out_valid, 1);
         @(posedge clk); #1;
      end

      // Streaming: 4 back-to-back beats, results on consecutive cycles
      n0 = nout; i0 = nin;
      for (int k = 0; k < 4; k++) begin
         drive(k);
         @(negedge clk);
         chk($sformatf("stream_ready[%0d]", k), in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_drain(20);
      chk("stream_count", nout - n0, 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("stream_latency[%0d]", k), out_cycle[n0+k] - in_cycle[i0+k], 2);
         chk($sformatf("stream_gap[%0d]", k), out_cycle[n0+k] - out_cycle[n0], k);
      end

      // Backpressure: two beats fill both slots, third is refused
      out_ready = 1'b0;
      n0 = nout;
      drive(8);
      @(negedge clk); chk("bp_ready0", in_ready, 1);
      @(posedge clk); #1;
      drive(9);
      @(negedge clk); chk("bp_ready1", in_ready, 1);
      @(posedge clk); #1;
      drive(10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp_stall_ready[%0d]", k), in_ready,  0);
         chk($sformatf("bp_stall_valid[%0d]", k), out_valid, 1);
         chk($sformatf("bp_stall_sum[%0d]", k),   sum,       tbl[8].sum);
         chk($sformatf("bp_stall_flags[%0d]", k), {cout, ovf, grp_p, grp_g},
             {tbl[8].cout, tbl[8].ovf, tbl[8].gp, tbl[8].gg});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      acc = 0;
      for (int c = 0; c < 5 && acc == 0; c++) begin
         @(negedge clk);
         if (in_ready) acc = 1;
         @(posedge clk); #1;
      end
      chk("bp_third_accepted", acc, 1);
      in_valid = 1'b0;
      wait_drain(20);
      chk("bp_count", nout - n0, 3);

      // Reset with two beats in flight
      out_ready = 1'b0;
      drive(11);
      @(posedge clk); #1;
      drive(12);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum",       sum,       0);
      chk("midrst_flags",     {cout, ovf, grp_p, grp_g}, 0);
      chk("midrst_in_ready1", in_ready,  1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("midrst_no_stale[%0d]", k), out_valid, 0);
      end

      // A fresh beat after reset goes through normally
      @(posedge clk); #1;
      n0 = nout;
      drive(13);
      @(negedge clk); chk("post_midrst_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_drain(10);
      chk("post_midrst_count", nout - n0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
